// File: rtl/aes_sbox_sched_pkg.sv
// aes_sbox_sched_pkg: shared types and constants for the masked S-box scheduler
package aes_sbox_sched_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

    localparam int SBOX_STAGES = 4;
    localparam logic [SBOX_STAGES-1:0] WE_NONE   = '0;
    localparam logic [SBOX_STAGES-1:0] WE_STAGE0 = 4'b0001;

    function automatic logic [SBOX_STAGES-1:0] stage_we(input logic [1:0] c);
        return WE_STAGE0 << c;
    endfunction

endpackage

// File: rtl/aes_sbox_rr_arb.sv
// aes_sbox_rr_arb: round-robin grant, first set lane at or after the pointer
module aes_sbox_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               valid
);

    // scan from the farthest lane back toward ptr so the nearest requester wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                grant = ID_W'((int'(ptr) + i) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_sbox_dom_sched.sv
// aes_sbox_dom_sched: shares one DOM masked S-box among NUM_REQ lanes (option AES_SBOX_SCHED_CLR_EN wipes operands after each result)
module aes_sbox_dom_sched
    import aes_sbox_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*8-1:0]   data_i,
    input  logic [NUM_REQ*8-1:0]   mask_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [7:0]             sbox_data_o,
    output logic [7:0]             sbox_mask_o,
    output logic [SBOX_STAGES-1:0] sbox_we_o,
    input  logic [7:0]             sbox_data_i,
    input  logic [7:0]             sbox_mask_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ID_W-1:0]        out_id_o,
    output logic [7:0]             out_data_o,
    output logic [7:0]             out_mask_o,
    output logic                   busy_o
);

    state_e          state;
    logic [1:0]      cnt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant;
    logic            gnt_valid;

    aes_sbox_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_i),
        .ptr   (ptr),
        .grant (grant),
        .valid (gnt_valid)
    );

    // decode handshake and stage enables from registered state; result is never unmasked here
    always_comb begin
        ack_o       = (state == IDLE && gnt_valid) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant : '0;
        sbox_we_o   = (state == EVAL) ? stage_we(cnt) : WE_NONE;
        out_valid_o = (state == DONE);
        out_data_o  = out_valid_o ? sbox_data_i : 8'h00;
        out_mask_o  = out_valid_o ? sbox_mask_i : 8'h00;
        busy_o      = (state != IDLE);
    end

    // scheduler FSM: grant and latch in IDLE, step the S-box stages, hold result until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            ptr         <= '0;
            out_id_o    <= '0;
            sbox_data_o <= 8'h00;
            sbox_mask_o <= 8'h00;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    sbox_data_o <= data_i[8*grant +: 8];
                    sbox_mask_o <= mask_i[8*grant +: 8];
                    out_id_o    <= grant;
                    ptr         <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                    cnt         <= 2'd0;
                    state       <= EVAL;
                end
                EVAL: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(SBOX_STAGES - 1)) state <= DONE;
                end
                DONE: if (out_ready_i) begin
`ifdef AES_SBOX_SCHED_CLR_EN
                    sbox_data_o <= 8'h00;
                    sbox_mask_o <= 8'h00;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sbox_dom_sched.sv
// tb_aes_sbox_dom_sched: directed bench for the masked S-box scheduler with a behavioural S-box stand-in
module tb_aes_sbox_dom_sched;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  req;
    logic [31:0] data, mask;
    logic [3:0]  ack;
    logic [7:0]  sdo, smo, sdi, smi;
    logic [3:0]  we;
    logic        valid, ready, busy;
    logic [1:0]  id;
    logic [7:0]  od, om;
    int          checks = 0;
    int          failures = 0;

`ifdef AES_SBOX_SCHED_CLR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    always #5 clk = ~clk;

    aes_sbox_dom_sched #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .data_i      (data),
        .mask_i      (mask),
        .ack_o       (ack),
        .sbox_data_o (sdo),
        .sbox_mask_o (smo),
        .sbox_we_o   (we),
        .sbox_data_i (sdi),
        .sbox_mask_i (smi),
        .out_valid_o (valid),
        .out_ready_i (ready),
        .out_id_o    (id),
        .out_data_o  (od),
        .out_mask_o  (om),
        .busy_o      (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // stand-in for the shared S-box: remasks its result with a mask derived from the input mask
    assign smi = smo ^ 8'h3C;
    assign sdi = sbox_f(sdo ^ smo) ^ smi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [7:0] x, input logic [7:0] m);
        data[8*k +: 8] = x ^ m;
        mask[8*k +: 8] = m;
    endtask

    // from IDLE with requests set: expect grant to lane, walk the 4 stages, stop in DONE
    task automatic txn(input int lane, input logic [7:0] x, input logic [7:0] m, input logic [7:0] s);
        #1;
        chk("ack_grant", 32'(ack), 32'(1 << lane));
        chk("idle_busy", 32'(busy), 0);
        step();
        chk("ack_after", 32'(ack), 0);
        chk("sbox_data", 32'(sdo), 32'(x ^ m));
        chk("sbox_mask", 32'(smo), 32'(m));
        for (int i = 0; i < 4; i++) begin
            chk("stage_we", 32'(we), 32'(1 << i));
            chk("eval_valid", 32'(valid), 0);
            step();
        end
        chk("done_valid", 32'(valid), 1);
        chk("done_we", 32'(we), 0);
        chk("done_id", 32'(id), 32'(lane));
        chk("done_unmasked", 32'(od ^ om), 32'(s));
        chk("done_mask", 32'(om), 32'(m ^ 8'h3C));
    endtask

    initial begin
        req = 4'b0000;
        data = '0;
        mask = '0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_smo", 32'(smo), 0);
        chk("rst_od", 32'(od), 0);
        chk("rst_om", 32'(om), 0);
        rst_ni = 1'b1;
        step();
        chk("idle_no_req", 32'(busy), 0);

        // single lane, then hold the result under backpressure
        set_lane(0, 8'h00, 8'hA5);
        req = 4'b0001;
        txn(0, 8'h00, 8'hA5, 8'h63);
        set_lane(1, 8'h01, 8'h5A);
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(valid), 1);
            chk("bp_we", 32'(we), 0);
            chk("bp_ack", 32'(ack), 0);
            chk("bp_result", 32'(od ^ om), 32'h63);
            chk("bp_sdo", 32'(sdo), 32'hA5);
        end
        ready = 1'b1;
        req = 4'b0000;
        step();
        chk("hs_busy", 32'(busy), 0);
        chk("hs_valid", 32'(valid), 0);
        chk("hs_od", 32'(od), 0);
        chk("hs_sdo", 32'(sdo), CLR ? 32'h00 : 32'hA5);
        chk("hs_smo", 32'(smo), CLR ? 32'h00 : 32'hA5);

        // pointer is 1: lane 2 moves it to 3, then 0101 grants 0 then 2
        set_lane(2, 8'h53, 8'h3C);
        req = 4'b0100;
        txn(2, 8'h53, 8'h3C, 8'hED);
        set_lane(0, 8'h01, 8'hC3);
        req = 4'b0101;
        step();
        txn(0, 8'h01, 8'hC3, 8'h7C);
        step();
        txn(2, 8'h53, 8'h3C, 8'hED);

        // lane 3 granted, reset asserted with stage counter at 2
        set_lane(3, 8'h10, 8'h77);
        req = 4'b1000;
        step();
        chk("l3_ack", 32'(ack), 32'b1000);
        step();
        step();
        step();
        chk("l3_we2", 32'(we), 32'b0100);
        rst_ni = 1'b0;
        req = 4'b0000;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_we", 32'(we), 0);
        chk("mid_rst_sdo", 32'(sdo), 0);
        chk("mid_rst_smo", 32'(smo), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        step();
        chk("mid_rst_hold_we", 32'(we), 0);
        chk("mid_rst_hold_ack", 32'(ack), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();

        // all lanes requesting from a reset pointer
        set_lane(0, 8'h00, 8'h11);
        set_lane(1, 8'h01, 8'h22);
        set_lane(2, 8'h53, 8'h44);
        set_lane(3, 8'h10, 8'h88);
        req = 4'b1111;
        txn(0, 8'h00, 8'h11, 8'h63);
        step();
        txn(1, 8'h01, 8'h22, 8'h7C);
        step();
        txn(2, 8'h53, 8'h44, 8'hED);
        step();
        txn(3, 8'h10, 8'h88, 8'hCA);
        step();
        txn(0, 8'h00, 8'h11, 8'h63);
        req = 4'b0000;
        step();
        chk("final_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
